// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Time-multiplexed driver for a 4-digit common-anode seven-segment display.
//   It scans one digit slot every REFRESH_DIV clocks and latches the four BCD
//   digits and the decimal-point mask once per frame, so a frame never shows
//   a mix of old and new values. It also blanks leading zeros, can blink the
//   whole display, and drives a decimal point for each digit.
//
// Ports
//   clk       system clock
//   rst       synchronous, active-high reset
//   digit1..4 BCD digits, digit1 = thousands (leftmost) .. digit4 = units
//   dp_mask   decimal-point request, bit3 = digit1 position .. bit0 = digit4
//   blink_en  1 = blink the whole display at BLINK_FRAMES frames per half-period
//   an        anode enables, active-low, an[3] = leftmost digit
//   seg       cathodes, active-low, {g,f,e,d,c,b,a}
//   dp        decimal-point cathode, active-low
module seg7_scan_driver #(
  parameter int REFRESH_DIV   = 100000,
  parameter int BLINK_FRAMES  = 125,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] digit1,
  input  logic [3:0] digit2,
  input  logic [3:0] digit3,
  input  logic [3:0] digit4,
  input  logic [3:0] dp_mask,
  input  logic       blink_en,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int CNT_W   = $clog2(REFRESH_DIV);
  localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0]   CNT_MAX   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_FRAMES - 1);

  localparam logic [6:0] SEG_OFF = 7'b1111111;
  localparam logic [3:0] AN_OFF  = 4'b1111;

  typedef enum logic [1:0] {
    SLOT_D1 = 2'd0,
    SLOT_D2 = 2'd1,
    SLOT_D3 = 2'd2,
    SLOT_D4 = 2'd3
  } slot_e;

  // Active-low cathode pattern for one BCD code; 10..15 show a dash.
  function automatic logic [6:0] decode(input logic [3:0] code);
    case (code)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  // State
  logic [CNT_W-1:0]   cnt_q,         cnt_d;
  slot_e              sel_q,         sel_d;
  logic [3:0][3:0]    snap_q,        snap_d;     // snap_q[0] = digit1
  logic [3:0]         snap_dp_q,     snap_dp_d;  // same bit order as dp_mask
  logic               frame_valid_q, frame_valid_d;
  logic [BLINK_W-1:0] blink_cnt_q,   blink_cnt_d;
  logic               blink_phase_q, blink_phase_d;
  logic [3:0]         an_q,          an_d;
  logic [6:0]         seg_q,         seg_d;
  logic               dp_q,          dp_d;

  // Combinational helpers
  logic       tick;
  logic       frame_start;
  logic [1:0] sel_idx;
  logic [3:0] cur_digit;
  logic       blank_slot;
  logic       dp_on;
  logic       dark;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    tick          = (cnt_q == CNT_MAX);
    frame_start   = tick && (sel_q == SLOT_D4);
    sel_idx       = sel_q;

    cnt_d         = tick ? '0 : cnt_q + 1'b1;
    sel_d         = tick ? slot_e'(sel_idx + 2'd1) : sel_q;
    snap_d        = snap_q;
    snap_dp_d     = snap_dp_q;
    frame_valid_d = frame_valid_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;

    if (frame_start) begin
      snap_d        = {digit4, digit3, digit2, digit1};
      snap_dp_d     = dp_mask;
      frame_valid_d = 1'b1;
    end

    // Blink timing only advances while blinking is requested; dropping
    // blink_en parks it in the visible phase.
    if (!blink_en) begin
      blink_cnt_d   = '0;
      blink_phase_d = 1'b0;
    end else if (frame_start) begin
      if (blink_cnt_q == BLINK_MAX) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d   = blink_cnt_q + 1'b1;
      end
    end

    // Output stage works from the pre-edge slot, so pins trail sel by a cycle.
    cur_digit = snap_q[sel_idx];
    // dp_mask bit3 belongs to slot 0, so the slot index is mirrored.
    dp_on     = snap_dp_q[~sel_idx];

    blank_slot = 1'b0;
    if (BLANK_LEADING) begin
      case (sel_q)
        SLOT_D1: blank_slot = (snap_q[0] == 4'd0);
        SLOT_D2: blank_slot = (snap_q[0] == 4'd0) && (snap_q[1] == 4'd0);
        SLOT_D3: blank_slot = (snap_q[0] == 4'd0) && (snap_q[1] == 4'd0) &&
                              (snap_q[2] == 4'd0);
        default: blank_slot = 1'b0;
      endcase
    end

    // Gating the phase with the live blink_en lets the display come back on
    // the very next update after blinking is switched off.
    dark = !frame_valid_q || (blink_en && blink_phase_q);

    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if (!dark) begin
      // A blanked slot still lights its anode when its decimal point is on.
      if (!blank_slot || dp_on) an_d = ~(4'b1000 >> sel_idx);
      if (!blank_slot)          seg_d = decode(cur_digit);
      dp_d = ~dp_on;
    end
  end

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= CNT_MAX;
      sel_q         <= SLOT_D4;
      snap_q        <= '0;
      snap_dp_q     <= '0;
      frame_valid_q <= 1'b0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      an_q          <= AN_OFF;
      seg_q         <= SEG_OFF;
      dp_q          <= 1'b1;
    end else begin
      cnt_q         <= cnt_d;
      sel_q         <= sel_d;
      snap_q        <= snap_d;
      snap_dp_q     <= snap_dp_d;
      frame_valid_q <= frame_valid_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule
